// File: rtl/trap_pkg.sv
// trap_pkg: shared definitions for the supervisor trap controller.
//   - state_e        : trap FSM state encoding (also exposed in status[5:3])
//   - CSR_*          : CSR address map for csr_addr
//   - CAUSE_*        : exception class codes found in scause[63:61]
//   - STATUS_*       : bit positions inside the status CSR
// Optional feature macro used by the users of this package: TRAP_COUNTER_EN.
package trap_pkg;

    typedef enum logic [2:0] {
        StRun       = 3'd0,
        StTrapFlush = 3'd1,
        StHandler   = 3'd2,
        StRetFlush  = 3'd3,
        StHalt      = 3'd4
    } state_e;

    localparam logic [1:0] CSR_SEPC   = 2'd0;
    localparam logic [1:0] CSR_SCAUSE = 2'd1;
    localparam logic [1:0] CSR_STVEC  = 2'd2;
    localparam logic [1:0] CSR_STATUS = 2'd3;

    localparam logic [2:0] CAUSE_LOAD   = 3'b000;
    localparam logic [2:0] CAUSE_STORE  = 3'b001;
    localparam logic [2:0] CAUSE_ALU    = 3'b010;
    localparam logic [2:0] CAUSE_BRANCH = 3'b011;

    localparam int unsigned STATUS_IE         = 0;
    localparam int unsigned STATUS_IN_HANDLER = 1;
    localparam int unsigned STATUS_DF         = 2;
    localparam int unsigned STATUS_STATE_LSB  = 3;
    localparam int unsigned STATUS_STATE_MSB  = 5;
    localparam int unsigned STATUS_CNT_LSB    = 16;
    localparam int unsigned STATUS_CNT_MSB    = 31;

endpackage

// File: rtl/trap_csr_file.sv
// trap_csr_file: supervisor trap CSRs (sepc, scause, stvec, status), write
// decode and combinational read mux.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   wr_en             : CSR write, already qualified by the FSM
//   addr, wdata       : CSR address / write data
//   rdata             : zero-extended read data for addr
//   trap_latch        : capture sepc_in/scause_in (wins over a CSR write)
//   sepc_in, scause_in: faulting PC and cause
//   set_df            : record a double fault in status.df
//   trap_accept       : a trap was accepted (feeds the optional counter)
//   state, in_handler : FSM view reflected in status
//   sepc, stvec       : current register values for redirect targets
// With TRAP_COUNTER_EN defined, a 16-bit saturating trap counter is kept and
// shown in status[31:16]; any status write clears it.
module trap_csr_file
    import trap_pkg::*;
#(
    parameter int unsigned     PC_W      = 15,
    parameter int unsigned     CAUSE_W   = 64,
    parameter logic [PC_W-1:0] STVEC_RST = 15'h1F00
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [1:0]         addr,
    input  logic [CAUSE_W-1:0] wdata,
    output logic [CAUSE_W-1:0] rdata,
    input  logic               trap_latch,
    input  logic [PC_W-1:0]    sepc_in,
    input  logic [CAUSE_W-1:0] scause_in,
    input  logic               set_df,
    input  logic               trap_accept,
    input  state_e             state,
    input  logic               in_handler,
    output logic [PC_W-1:0]    sepc,
    output logic [PC_W-1:0]    stvec
);

    logic [PC_W-1:0]    sepc_q;
    logic [CAUSE_W-1:0] scause_q;
    logic [PC_W-1:0]    stvec_q;
    logic               ie_q;
    logic               df_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sepc_q   <= '0;
            scause_q <= '0;
            stvec_q  <= STVEC_RST;
            ie_q     <= 1'b0;
            df_q     <= 1'b0;
        end else begin
            if (wr_en) begin
                unique case (addr)
                    CSR_SEPC:   sepc_q   <= wdata[PC_W-1:0];
                    CSR_SCAUSE: scause_q <= wdata;
                    CSR_STVEC:  stvec_q  <= wdata[PC_W-1:0];
                    CSR_STATUS: ie_q     <= wdata[STATUS_IE];
                    default:    ;
                endcase
            end
            // Hardware capture of a faulting instruction overrides software.
            if (trap_latch) begin
                sepc_q   <= sepc_in;
                scause_q <= scause_in;
            end
            if (set_df) begin
                df_q <= 1'b1;
            end
        end
    end

`ifdef TRAP_COUNTER_EN
    logic [15:0] trap_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            trap_cnt_q <= '0;
        end else if (wr_en && (addr == CSR_STATUS)) begin
            trap_cnt_q <= '0;
        end else if (trap_accept && (trap_cnt_q != 16'hFFFF)) begin
            trap_cnt_q <= trap_cnt_q + 16'd1;
        end
    end
`else
    logic unused_trap_accept;
    assign unused_trap_accept = trap_accept;
`endif

    always_comb begin
        rdata = '0;
        unique case (addr)
            CSR_SEPC:   rdata[PC_W-1:0] = sepc_q;
            CSR_SCAUSE: rdata = scause_q;
            CSR_STVEC:  rdata[PC_W-1:0] = stvec_q;
            CSR_STATUS: begin
                rdata[STATUS_IE]                         = ie_q;
                rdata[STATUS_IN_HANDLER]                 = in_handler;
                rdata[STATUS_DF]                         = df_q;
                rdata[STATUS_STATE_MSB:STATUS_STATE_LSB] = state;
`ifdef TRAP_COUNTER_EN
                rdata[STATUS_CNT_MSB:STATUS_CNT_LSB]     = trap_cnt_q;
`endif
            end
            default: ;
        endcase
    end

    assign sepc  = sepc_q;
    assign stvec = stvec_q;

endmodule

// File: rtl/trap_controller.sv
// trap_controller: consumer of the EXE-stage exception pulse. Captures the
// faulting PC/cause, redirects fetch to stvec, flushes the pipeline, tracks
// handler execution and returns to sepc + PC_STEP on SRET.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   exception, sepc_in,
//   scause_in             : exception pulse with faulting PC and cause
//   sret                  : SRET committed in EXE
//   csr_we, csr_addr,
//   csr_wdata, csr_rdata  : CSR access (writes honoured only in HANDLER)
//   pc_redirect,
//   redirect_pc           : one-cycle fetch redirect and its target
//   flush                 : squash IF/ID/EXE
//   in_handler            : trap handler running
//   halted                : double fault, core must stop
// Optional feature macro: TRAP_COUNTER_EN (trap counter in status[31:16]).
module trap_controller
    import trap_pkg::*;
#(
    parameter int unsigned     PC_W         = 15,
    parameter int unsigned     CAUSE_W      = 64,
    parameter logic [PC_W-1:0] STVEC_RST    = 15'h1F00,
    parameter int unsigned     FLUSH_CYCLES = 2,
    parameter int unsigned     PC_STEP      = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               exception,
    input  logic [PC_W-1:0]    sepc_in,
    input  logic [CAUSE_W-1:0] scause_in,
    input  logic               sret,
    input  logic               csr_we,
    input  logic [1:0]         csr_addr,
    input  logic [CAUSE_W-1:0] csr_wdata,
    output logic [CAUSE_W-1:0] csr_rdata,
    output logic               pc_redirect,
    output logic [PC_W-1:0]    redirect_pc,
    output logic               flush,
    output logic               in_handler,
    output logic               halted
);

    localparam logic [2:0]      FLUSH_LAST = 3'(FLUSH_CYCLES - 1);
    localparam logic [PC_W-1:0] PC_STEP_W  = PC_W'(PC_STEP);

    state_e          state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic            trap_latch, set_df, trap_accept;
    logic            csr_wr;
    logic [PC_W-1:0] sepc, stvec;

    assign csr_wr = csr_we && (state_q == StHandler);

    trap_csr_file #(
        .PC_W      (PC_W),
        .CAUSE_W   (CAUSE_W),
        .STVEC_RST (STVEC_RST)
    ) u_csr (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (csr_wr),
        .addr        (csr_addr),
        .wdata       (csr_wdata),
        .rdata       (csr_rdata),
        .trap_latch  (trap_latch),
        .sepc_in     (sepc_in),
        .scause_in   (scause_in),
        .set_df      (set_df),
        .trap_accept (trap_accept),
        .state       (state_q),
        .in_handler  (in_handler),
        .sepc        (sepc),
        .stvec       (stvec)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StRun;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pc_redirect = 1'b0;
        redirect_pc = '0;
        flush       = 1'b0;
        in_handler  = 1'b0;
        halted      = 1'b0;
        trap_latch  = 1'b0;
        set_df      = 1'b0;
        trap_accept = 1'b0;
        unique case (state_q)
            StRun: begin
                if (exception) begin
                    trap_latch  = 1'b1;
                    trap_accept = 1'b1;
                    state_d     = StTrapFlush;
                    cnt_d       = '0;
                end
            end
            StTrapFlush: begin
                flush = 1'b1;
                // The first flush cycle carries the redirect pulse.
                if (cnt_q == 3'd0) begin
                    pc_redirect = 1'b1;
                    redirect_pc = stvec;
                end
                if (cnt_q == FLUSH_LAST) begin
                    state_d = StHandler;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            StHandler: begin
                in_handler = 1'b1;
                if (exception) begin
                    trap_latch  = 1'b1;
                    set_df      = 1'b1;
                    trap_accept = 1'b1;
                    state_d     = StHalt;
                end else if (sret) begin
                    state_d = StRetFlush;
                    cnt_d   = '0;
                end
            end
            StRetFlush: begin
                flush = 1'b1;
                // sepc already holds any CSR write made alongside the sret.
                if (cnt_q == 3'd0) begin
                    pc_redirect = 1'b1;
                    redirect_pc = sepc + PC_STEP_W;
                end
                if (cnt_q == FLUSH_LAST) begin
                    state_d = StRun;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            StHalt: begin
                halted = 1'b1;
                flush  = 1'b1;
            end
            default: begin
                state_d = StRun;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_trap_controller.sv
module tb_trap_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        exception = 1'b0;
    logic [14:0] sepc_in = '0;
    logic [63:0] scause_in = '0;
    logic        sret = 1'b0;
    logic        csr_we = 1'b0;
    logic [1:0]  csr_addr = '0;
    logic [63:0] csr_wdata = '0;
    logic [63:0] csr_rdata;
    logic        pc_redirect;
    logic [14:0] redirect_pc;
    logic        flush;
    logic        in_handler;
    logic        halted;

    trap_controller u_dut (
        .clk         (clk),
        .rst         (rst),
        .exception   (exception),
        .sepc_in     (sepc_in),
        .scause_in   (scause_in),
        .sret        (sret),
        .csr_we      (csr_we),
        .csr_addr    (csr_addr),
        .csr_wdata   (csr_wdata),
        .csr_rdata   (csr_rdata),
        .pc_redirect (pc_redirect),
        .redirect_pc (redirect_pc),
        .flush       (flush),
        .in_handler  (in_handler),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [14:0] pc;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    logic [15:0] exp_cnt = '0;
    logic        exp_ie = 1'b0;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // Monitor: every redirect pulse must match the next queued expectation,
    // both in target and in the cycle it appears.
    initial forever begin
        @(negedge clk);
        if (!rst && pc_redirect) begin
            n_checks = n_checks + 1;
            if (exp_q.size() == 0) begin
                $display("FAIL redirect_unexpected: got redirect_pc=%h at cycle %0d, required no redirect",
                         redirect_pc, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (redirect_pc == e.pc && cyc == e.cyc) n_pass = n_pass + 1;
                else $display("FAIL redirect: got pc=%h cycle=%0d, required pc=%h cycle=%0d",
                              redirect_pc, cyc, e.pc, e.cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks = n_checks + 1;
        if (act === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got %h, required %h", name, act, exp);
    endtask

    // Reads a CSR at the negedge; consumes one clock cycle.
    task automatic rd_csr(input logic [1:0] a, output logic [63:0] v);
        csr_addr = a;
        @(negedge clk);
        v = csr_rdata;
        tick();
    endtask

    task automatic expect_redirect(input logic [14:0] pc);
        exp_q.push_back('{pc, cyc + 1});
    endtask

    function automatic logic [63:0] st_word(input logic ih, input logic df, input logic [2:0] st);
        logic [63:0] v;
        v = '0;
        v[0] = exp_ie;
        v[1] = ih;
        v[2] = df;
        v[5:3] = st;
`ifdef TRAP_COUNTER_EN
        v[31:16] = exp_cnt;
`endif
        return v;
    endfunction

    task automatic cnt_inc();
        if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    endtask

    task automatic do_trap(input logic [14:0] pc, input logic [63:0] cause, input logic [14:0] vec);
        sepc_in = pc;
        scause_in = cause;
        exception = 1'b1;
        expect_redirect(vec);
        tick();
        exception = 1'b0;
        cnt_inc();
        chk("trap_flush_c1", {63'd0, flush}, 64'd1);
        tick();
        chk("trap_flush_c2", {63'd0, flush}, 64'd1);
        chk("trap_no_handler_yet", {63'd0, in_handler}, 64'd0);
        tick();
        chk("handler_entered", {63'd0, in_handler}, 64'd1);
        chk("handler_flush_off", {63'd0, flush}, 64'd0);
    endtask

    task automatic do_ret(input logic [14:0] target);
        sret = 1'b1;
        expect_redirect(target);
        tick();
        sret = 1'b0;
        csr_we = 1'b0;
        chk("ret_flush_c1", {63'd0, flush}, 64'd1);
        tick();
        chk("ret_flush_c2", {63'd0, flush}, 64'd1);
        tick();
        chk("ret_run_flush", {63'd0, flush}, 64'd0);
        chk("ret_run_handler", {63'd0, in_handler}, 64'd0);
    endtask

    initial begin
        logic [63:0] v;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_pc_redirect", {63'd0, pc_redirect}, 64'd0);
        chk("rst_redirect_pc", {49'd0, redirect_pc}, 64'd0);
        chk("rst_flush", {63'd0, flush}, 64'd0);
        chk("rst_halted", {63'd0, halted}, 64'd0);
        rd_csr(2'd2, v); chk("rst_stvec", v, 64'h1F00);
        rd_csr(2'd0, v); chk("rst_sepc", v, 64'h0);
        rd_csr(2'd3, v); chk("rst_status", v, st_word(1'b0, 1'b0, 3'd0));

        // Basic trap and return
        do_trap(15'h0040, {3'b000, 57'b0, 4'b0010}, 15'h1F00);
        rd_csr(2'd0, v); chk("trap_sepc", v, 64'h40);
        rd_csr(2'd1, v); chk("trap_scause", v, 64'h2);
        rd_csr(2'd3, v); chk("handler_status", v, st_word(1'b1, 1'b0, 3'd2));
        do_ret(15'h0044);
        rd_csr(2'd3, v); chk("run_status", v, st_word(1'b0, 1'b0, 3'd0));

        // Ignored in RUN: sret and CSR write
        sret = 1'b1;
        tick();
        sret = 1'b0;
        chk("sret_run_no_redirect", {63'd0, pc_redirect}, 64'd0);
        csr_we = 1'b1; csr_addr = 2'd2; csr_wdata = 64'h1234;
        tick();
        csr_we = 1'b0;
        rd_csr(2'd2, v); chk("run_write_ignored", v, 64'h1F00);

        // Exception during TRAP_FLUSH must not relatch
        sepc_in = 15'h0200; scause_in = 64'h4000_0000_0000_0001; exception = 1'b1;
        expect_redirect(15'h1F00);
        tick();
        cnt_inc();
        sepc_in = 15'h0300; scause_in = 64'h6000_0000_0000_0009;
        tick();
        exception = 1'b0;
        tick();
        chk("tf_ignored_handler", {63'd0, in_handler}, 64'd1);
        rd_csr(2'd0, v); chk("tf_ignored_sepc", v, 64'h200);
        rd_csr(2'd1, v); chk("tf_ignored_scause", v, 64'h4000_0000_0000_0001);

        // CSR writes in HANDLER
        csr_we = 1'b1;
        csr_addr = 2'd2; csr_wdata = 64'h1000; tick();
        csr_addr = 2'd0; csr_wdata = 64'h0100; tick();
        csr_addr = 2'd3; csr_wdata = 64'hFFFF_FFFF_FFFF_FFFF; tick();
        csr_we = 1'b0;
        exp_ie = 1'b1;
        exp_cnt = '0;
        rd_csr(2'd2, v); chk("wr_stvec", v, 64'h1000);
        rd_csr(2'd0, v); chk("wr_sepc", v, 64'h100);
        rd_csr(2'd3, v); chk("wr_status", v, st_word(1'b1, 1'b0, 3'd2));
        do_ret(15'h0104);
        do_trap(15'h0010, 64'h6000_0000_0000_0003, 15'h1000);

        // Same-cycle sepc write and sret, with wrap-around
        csr_we = 1'b1; csr_addr = 2'd0; csr_wdata = 64'h7FFE;
        do_ret(15'h0002);

        // Double fault, exception beats sret
        do_trap(15'h0020, 64'h2, 15'h1000);
        sepc_in = 15'h0030; scause_in = 64'h6000_0000_0000_0005;
        exception = 1'b1; sret = 1'b1;
        tick();
        exception = 1'b0; sret = 1'b0;
        cnt_inc();
        chk("df_halted", {63'd0, halted}, 64'd1);
        chk("df_flush", {63'd0, flush}, 64'd1);
        chk("df_in_handler", {63'd0, in_handler}, 64'd0);
        rd_csr(2'd1, v); chk("df_scause", v, 64'h6000_0000_0000_0005);
        rd_csr(2'd0, v); chk("df_sepc", v, 64'h30);
        rd_csr(2'd3, v); chk("df_status", v, st_word(1'b0, 1'b1, 3'd4));
        sret = 1'b1;
        tick();
        sret = 1'b0;
        tick();
        chk("df_still_halted", {63'd0, halted}, 64'd1);
        rst = 1'b1; tick(); rst = 1'b0;
        exp_ie = 1'b0; exp_cnt = '0;
        chk("df_rst_halted", {63'd0, halted}, 64'd0);
        chk("df_rst_flush", {63'd0, flush}, 64'd0);
        rd_csr(2'd3, v); chk("df_rst_status", v, st_word(1'b0, 1'b0, 3'd0));
        rd_csr(2'd1, v); chk("df_rst_scause", v, 64'h0);

        // Reset during TRAP_FLUSH
        sepc_in = 15'h0050; scause_in = 64'h2; exception = 1'b1;
        expect_redirect(15'h1F00);
        tick();
        exception = 1'b0;
        tick();
        rst = 1'b1; tick(); rst = 1'b0;
        exp_cnt = '0;
        chk("tfrst_pc_redirect", {63'd0, pc_redirect}, 64'd0);
        chk("tfrst_redirect_pc", {49'd0, redirect_pc}, 64'd0);
        chk("tfrst_flush", {63'd0, flush}, 64'd0);
        chk("tfrst_in_handler", {63'd0, in_handler}, 64'd0);
        chk("tfrst_halted", {63'd0, halted}, 64'd0);
        rd_csr(2'd2, v); chk("tfrst_stvec", v, 64'h1F00);
        rd_csr(2'd0, v); chk("tfrst_sepc", v, 64'h0);

`ifdef TRAP_COUNTER_EN
        do_trap(15'h0040, 64'h2, 15'h1F00);
        do_ret(15'h0044);
        do_trap(15'h0040, 64'h2, 15'h1F00);
        do_ret(15'h0044);
        do_trap(15'h0040, 64'h2, 15'h1F00);
        rd_csr(2'd3, v); chk("cnt_three", {48'd0, v[31:16]}, 64'd3);
        do_ret(15'h0044);
        force u_dut.u_csr.trap_cnt_q = 16'hFFFF;
        tick();
        release u_dut.u_csr.trap_cnt_q;
        exp_cnt = 16'hFFFF;
        do_trap(15'h0040, 64'h2, 15'h1F00);
        rd_csr(2'd3, v); chk("cnt_saturate", {48'd0, v[31:16]}, 64'hFFFF);
        do_ret(15'h0044);
`else
        do_trap(15'h0040, 64'h2, 15'h1F00);
        rd_csr(2'd3, v); chk("cnt_absent", {48'd0, v[31:16]}, 64'd0);
        do_ret(15'h0044);
`endif

        tick();
        chk("redirects_all_seen", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
